// File: rtl/id_part_if.sv
//------------------------------------------------------------------------------
// Module : id_part_if
// Brief  : Decode-stage bus carrying instruction, write-back and decode results.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface id_part_if;
  logic [31:0] PC;
  logic [31:0] IR;
  logic [31:0] Din;
  logic        WE;
  logic [4:0]  RW;
  logic [31:0] PCOut;
  logic [31:0] IROut;
  logic [31:0] signal;
  logic [31:0] R1;
  logic [31:0] R2;
  logic [31:0] R1Data;
  logic [31:0] R2Data;
  logic [31:0] RWOut;

  modport master (
    output PC, IR, Din, WE, RW,
    input  PCOut, IROut, signal, R1, R2, R1Data, R2Data, RWOut
  );

  modport slave (
    input  PC, IR, Din, WE, RW,
    output PCOut, IROut, signal, R1, R2, R1Data, R2Data, RWOut
  );
endinterface

`default_nettype wire

// File: rtl/id_part.sv
//------------------------------------------------------------------------------
// Module : id_part
// Brief  : Instruction decode with 32x32 register file and write-through bypass.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_part (
  input  wire logic clk,
  input  wire logic rst,
  id_part_if.slave  bus
);
  localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_J    = 6'h02, c_OP_JAL  = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04, c_OP_BNE  = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08, c_OP_ADDIU = 6'h09, c_OP_SLTI = 6'h0A;
  localparam logic [5:0] c_OP_SLTIU = 6'h0B, c_OP_ANDI = 6'h0C, c_OP_ORI  = 6'h0D;
  localparam logic [5:0] c_OP_XORI  = 6'h0E, c_OP_LUI  = 6'h0F;
  localparam logic [5:0] c_OP_LB    = 6'h20, c_OP_LH   = 6'h21, c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_LBU   = 6'h24, c_OP_LHU  = 6'h25;
  localparam logic [5:0] c_OP_SB    = 6'h28, c_OP_SH   = 6'h29, c_OP_SW   = 6'h2B;

  localparam logic [1:0] c_SZ_WORD = 2'b00, c_SZ_HALF = 2'b01, c_SZ_BYTE = 2'b10;

  logic [31:0] r_regs [32];

  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt, w_rd;
  logic [4:0] w_r1, w_r2, w_rw;
  logic [3:0] w_aluop;
  logic       w_regwrite, w_memread, w_memwrite, w_alusrcimm, w_immzext;
  logic       w_beq, w_bne, w_jump, w_jumpreg, w_link, w_shamt, w_syscall;
  logic [1:0] w_memsize;
  logic       w_memsext;
  logic       w_wr_en;

  assign w_op    = bus.IR[31:26];
  assign w_rs    = bus.IR[25:21];
  assign w_rt    = bus.IR[20:16];
  assign w_rd    = bus.IR[15:11];
  assign w_funct = bus.IR[5:0];

  always_comb begin
    w_r1 = 5'd0; w_r2 = 5'd0; w_rw = 5'd0; w_aluop = 4'd0;
    w_regwrite = 1'b0; w_memread = 1'b0; w_memwrite = 1'b0;
    w_alusrcimm = 1'b0; w_immzext = 1'b0; w_beq = 1'b0; w_bne = 1'b0;
    w_jump = 1'b0; w_jumpreg = 1'b0; w_link = 1'b0; w_shamt = 1'b0;
    w_syscall = 1'b0; w_memsize = c_SZ_WORD; w_memsext = 1'b0;
    case (w_op)
      c_OP_RTYPE: begin
        case (w_funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            w_regwrite = 1'b1; w_r1 = w_rs; w_r2 = w_rt; w_rw = w_rd;
            case (w_funct)
              6'h22, 6'h23: w_aluop = 4'd1;
              6'h24:        w_aluop = 4'd2;
              6'h25:        w_aluop = 4'd3;
              6'h26:        w_aluop = 4'd4;
              6'h27:        w_aluop = 4'd5;
              6'h2A:        w_aluop = 4'd6;
              6'h2B:        w_aluop = 4'd7;
              default:      w_aluop = 4'd0;
            endcase
          end
          6'h00, 6'h02, 6'h03: begin
            w_regwrite = 1'b1; w_shamt = 1'b1; w_r1 = w_rt; w_rw = w_rd;
            w_aluop = (w_funct == 6'h00) ? 4'd8 : (w_funct == 6'h02) ? 4'd9 : 4'd10;
          end
          6'h04, 6'h06, 6'h07: begin
            w_regwrite = 1'b1; w_r1 = w_rt; w_r2 = w_rs; w_rw = w_rd;
            w_aluop = (w_funct == 6'h04) ? 4'd8 : (w_funct == 6'h06) ? 4'd9 : 4'd10;
          end
          6'h08: begin
            w_jumpreg = 1'b1; w_r1 = w_rs;
          end
          6'h0C: begin
            // Service number lives in $v0, first argument in $a0
            w_syscall = 1'b1; w_r1 = 5'd2; w_r2 = 5'd4;
          end
          default: ;
        endcase
      end
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
      c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
        w_regwrite = 1'b1; w_alusrcimm = 1'b1; w_r1 = w_rs; w_rw = w_rt;
        w_immzext = (w_op >= c_OP_ANDI);
        case (w_op)
          c_OP_SLTI:  w_aluop = 4'd6;
          c_OP_SLTIU: w_aluop = 4'd7;
          c_OP_ANDI:  w_aluop = 4'd2;
          c_OP_ORI:   w_aluop = 4'd3;
          c_OP_XORI:  w_aluop = 4'd4;
          c_OP_LUI:   w_aluop = 4'd11;
          default:    w_aluop = 4'd0;
        endcase
      end
      c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU: begin
        w_memread = 1'b1; w_regwrite = 1'b1; w_alusrcimm = 1'b1;
        w_r1 = w_rs; w_rw = w_rt;
        w_memsize = (w_op == c_OP_LW) ? c_SZ_WORD :
                    (w_op == c_OP_LH || w_op == c_OP_LHU) ? c_SZ_HALF : c_SZ_BYTE;
        w_memsext = (w_op == c_OP_LB || w_op == c_OP_LH);
      end
      c_OP_SB, c_OP_SH, c_OP_SW: begin
        w_memwrite = 1'b1; w_alusrcimm = 1'b1; w_r1 = w_rs; w_r2 = w_rt;
        w_memsize = (w_op == c_OP_SW) ? c_SZ_WORD :
                    (w_op == c_OP_SH) ? c_SZ_HALF : c_SZ_BYTE;
      end
      c_OP_BEQ, c_OP_BNE: begin
        w_aluop = 4'd1; w_r1 = w_rs; w_r2 = w_rt;
        w_beq = (w_op == c_OP_BEQ); w_bne = (w_op == c_OP_BNE);
      end
      c_OP_J:   w_jump = 1'b1;
      c_OP_JAL: begin
        w_jump = 1'b1; w_link = 1'b1; w_regwrite = 1'b1; w_rw = 5'd31;
      end
      default: ;
    endcase
  end

  assign bus.signal = {13'd0, w_memsext, w_memsize, w_syscall, w_shamt, w_link,
                       w_jumpreg, w_jump, w_bne, w_beq, w_immzext, w_alusrcimm,
                       w_memwrite, w_memread, w_regwrite && (w_rw != 5'd0), w_aluop};
  assign bus.PCOut  = bus.PC;
  assign bus.IROut  = bus.IR;
  assign bus.R1     = {27'd0, w_r1};
  assign bus.R2     = {27'd0, w_r2};
  assign bus.RWOut  = {27'd0, w_rw};

  assign w_wr_en = bus.WE && (bus.RW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_wr_en) begin
      r_regs[bus.RW] <= bus.Din;
    end
  end

  // Same-cycle write-through so a dependent read never sees stale data
  assign bus.R1Data = (w_r1 == 5'd0) ? 32'd0 :
                      (w_wr_en && bus.RW == w_r1) ? bus.Din : r_regs[w_r1];
  assign bus.R2Data = (w_r2 == 5'd0) ? 32'd0 :
                      (w_wr_en && bus.RW == w_r2) ? bus.Din : r_regs[w_r2];
endmodule

`default_nettype wire

// File: tb/tb_id_part.sv
//------------------------------------------------------------------------------
// Module : tb_id_part
// Brief  : Directed-vector scoreboard bench for id_part.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_part;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_part_if bus ();

  id_part dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  localparam int c_PCO = 0, c_IRO = 1, c_SIG = 2, c_R1 = 3, c_R2 = 4;
  localparam int c_R1D = 5, c_R2D = 6, c_RWO = 7;

  task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
    item_t it;
    it.name = nm; it.sel = sel; it.exp = v;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: outputs are combinational, so compare at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t       it;
      logic [31:0] act;
      it = sb.pop_front();
      case (it.sel)
        c_PCO:   act = bus.PCOut;
        c_IRO:   act = bus.IROut;
        c_SIG:   act = bus.signal;
        c_R1:    act = bus.R1;
        c_R2:    act = bus.R2;
        c_R1D:   act = bus.R1Data;
        c_R2D:   act = bus.R2Data;
        default: act = bus.RWOut;
      endcase
      n_checks++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.PC = 32'd0; bus.IR = 32'd0; bus.Din = 32'd0; bus.WE = 1'b0; bus.RW = 5'd0;
    step();
    rst = 1'b0;

    // add $2,$3,$4 after reset
    bus.IR = 32'h00641020;
    expect_val("add_r1", c_R1, 32'd3);
    expect_val("add_r2", c_R2, 32'd4);
    expect_val("add_rw", c_RWO, 32'd2);
    expect_val("add_r1d_rst", c_R1D, 32'd0);
    expect_val("add_r2d_rst", c_R2D, 32'd0);
    expect_val("add_sig", c_SIG, 32'h00000010);
    step();

    // write reg3 = 10 over two edges, bypass visible beforehand
    bus.WE = 1'b1; bus.RW = 5'd3; bus.Din = 32'd10;
    expect_val("bypass_r3", c_R1D, 32'd10);
    step();
    step();
    bus.WE = 1'b0; bus.PC = 32'd40;
    expect_val("r3_stored", c_R1D, 32'd10);
    expect_val("pcout", c_PCO, 32'd40);
    expect_val("irout", c_IRO, 32'h00641020);
    step();

    bus.IR = 32'h0000000C;
    expect_val("sys_sig", c_SIG, 32'h00008000);
    expect_val("sys_r1", c_R1, 32'd2);
    expect_val("sys_r2", c_R2, 32'd4);
    expect_val("sys_rw", c_RWO, 32'd0);
    step();

    // write to reg 0 must be dropped
    bus.WE = 1'b1; bus.RW = 5'd0; bus.Din = 32'd5;
    step();
    bus.WE = 1'b0; bus.IR = 32'h00001020;
    expect_val("r0_read", c_R1D, 32'd0);
    step();

    bus.WE = 1'b1; bus.RW = 5'd4; bus.Din = 32'd7; bus.IR = 32'h00641020;
    expect_val("bypass_r4", c_R2D, 32'd7);
    expect_val("r3_kept", c_R1D, 32'd10);
    step();
    bus.WE = 1'b0;
    expect_val("r4_stored", c_R2D, 32'd7);
    step();

    bus.IR = 32'h8C450008;
    expect_val("lw_sig", c_SIG, 32'h000000B0);
    expect_val("lw_r1", c_R1, 32'd2);
    expect_val("lw_r2", c_R2, 32'd0);
    expect_val("lw_rw", c_RWO, 32'd5);
    step();

    bus.IR = 32'h0C000010;
    expect_val("jal_sig", c_SIG, 32'h00002810);
    expect_val("jal_rw", c_RWO, 32'd31);
    step();

    bus.IR = 32'hAC450008;
    expect_val("sw_sig", c_SIG, 32'h000000C0);
    expect_val("sw_r2", c_R2, 32'd5);
    expect_val("sw_rw", c_RWO, 32'd0);
    step();

    bus.IR = 32'h80450008;
    expect_val("lb_sig", c_SIG, 32'h000600B0);
    step();

    bus.IR = 32'h10640005;
    expect_val("beq_sig", c_SIG, 32'h00000201);
    expect_val("beq_r2", c_R2, 32'd4);
    expect_val("beq_rw", c_RWO, 32'd0);
    step();

    bus.IR = 32'h00031080;
    expect_val("sll_sig", c_SIG, 32'h00004018);
    expect_val("sll_r1", c_R1, 32'd3);
    expect_val("sll_r2", c_R2, 32'd0);
    step();

    bus.IR = 32'h34A60010;
    expect_val("ori_sig", c_SIG, 32'h00000193);
    expect_val("ori_rw", c_RWO, 32'd6);
    step();

    bus.IR = 32'h03E00008;
    expect_val("jr_sig", c_SIG, 32'h00001000);
    expect_val("jr_r1", c_R1, 32'd31);
    step();

    // reg7 = all ones, then reset clears it; WE during reset is ignored
    bus.WE = 1'b1; bus.RW = 5'd7; bus.Din = 32'hFFFFFFFF;
    step();
    bus.WE = 1'b0; bus.IR = 32'h00E01020;
    expect_val("r7_set", c_R1D, 32'hFFFFFFFF);
    step();
    rst = 1'b1; bus.WE = 1'b1; bus.RW = 5'd8; bus.Din = 32'h55;
    step();
    rst = 1'b0; bus.WE = 1'b0; bus.IR = 32'h00E81020;
    expect_val("r7_cleared", c_R1D, 32'd0);
    expect_val("r8_rst_we", c_R2D, 32'd0);
    step();

    bus.IR = 32'hFC000000;
    expect_val("unk_sig", c_SIG, 32'd0);
    expect_val("unk_rw", c_RWO, 32'd0);
    expect_val("unk_r1", c_R1, 32'd0);
    step();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
